dcache_wt_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache controller that sits between the CPU load/store stage and the byte-addressed data SRAM.
- Initiator side of the SRAM interface: drives w_en, address and write_data, and samples read_data.
- SRAM contract: read_data is combinational, returning mem[address..address+3], little-endian. A write commits at posedge clk according to w_en: 1111 = 4 bytes, 0011 = 2 bytes, 0001 = 1 byte, any other value = no write.
- The CPU side uses the same w_en encoding and a single outstanding request.

---
 rtl/dcache_pkg.sv | 65 ++++++
 rtl/dcache_array.sv | 75 +++++++
 rtl/dcache_wt_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_dcache_wt_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared types and helpers for the write-through data cache controller:
//   state_e       controller FSM states
//   W_EN_*        CPU/SRAM write-enable encodings (0000 read, 0001 byte,
//                 0011 half, 1111 word)
//   is_legal_w_en true for the four defined encodings
//   is_aligned    true when the access does not straddle a 32-bit word
//   merge_bytes   merges right-aligned store data into a cached word
// -----------------------------------------------------------------------------
package dcache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REFILL = 2'd1,
      ST_BYPASS = 2'd2,
      ST_WRITE  = 2'd3
   } state_e;

   localparam logic [3:0] W_EN_READ = 4'b0000;
   localparam logic [3:0] W_EN_BYTE = 4'b0001;
   localparam logic [3:0] W_EN_HALF = 4'b0011;
   localparam logic [3:0] W_EN_WORD = 4'b1111;

   function automatic logic is_legal_w_en(input logic [3:0] w_en);
      logic legal;
      case (w_en)
         W_EN_READ, W_EN_BYTE, W_EN_HALF, W_EN_WORD: legal = 1'b1;
         default:                                    legal = 1'b0;
      endcase
      return legal;
   endfunction

   // Reads are treated as word accesses; undefined encodings are never aligned.
   function automatic logic is_aligned(input logic [3:0] w_en, input logic [1:0] offset);
      logic aligned;
      case (w_en)
         W_EN_READ: aligned = (offset == 2'b00);
         W_EN_WORD: aligned = (offset == 2'b00);
         W_EN_HALF: aligned = (offset[0] == 1'b0);
         W_EN_BYTE: aligned = 1'b1;
         default:   aligned = 1'b0;
      endcase
      return aligned;
   endfunction

   // Store data is right-aligned; shift it and its byte mask up to the offset.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  w_en,
                                               input logic [1:0]  offset);
      logic [31:0] mask;
      logic [4:0]  shamt;
      case (w_en)
         W_EN_WORD: mask = 32'hFFFF_FFFF;
         W_EN_HALF: mask = 32'h0000_FFFF;
         W_EN_BYTE: mask = 32'h0000_00FF;
         default:   mask = 32'h0000_0000;
      endcase
      shamt = {offset, 3'b000};
      mask  = mask << shamt;
      return (old_word & ~mask) | ((wdata << shamt) & mask);
   endfunction

endpackage

// File: rtl/dcache_array.sv
// -----------------------------------------------------------------------------
// dcache_array
// Tag, valid and data storage of the direct-mapped cache.
//   clk, rst                       clock, synchronous clear of all valid bits
//   lk_index/lk_word/lk_tag        primary lookup -> lk_hit, lk_data (comb)
//   lk2_index/lk2_tag              secondary tag probe -> lk2_hit (comb)
//   wr_en/wr_index/wr_word/wr_data one data word write
//   set_valid/set_index/set_tag    install a tag and mark the line valid
//   inv_en/inv_index, inv2_en/inv2_index  clear valid of up to two lines
// -----------------------------------------------------------------------------
module dcache_array
   import dcache_pkg::*;
#(
   parameter  int LINES = 16,
   parameter  int WPL   = 4,
   parameter  int TAG_W = 8,
   localparam int IDX_W = $clog2(LINES),
   localparam int WRD_W = $clog2(WPL)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] lk_index,
   input  logic [WRD_W-1:0] lk_word,
   input  logic [TAG_W-1:0] lk_tag,
   output logic             lk_hit,
   output logic [31:0]      lk_data,
   input  logic [IDX_W-1:0] lk2_index,
   input  logic [TAG_W-1:0] lk2_tag,
   output logic             lk2_hit,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_index,
   input  logic [WRD_W-1:0] wr_word,
   input  logic [31:0]      wr_data,
   input  logic             set_valid,
   input  logic [IDX_W-1:0] set_index,
   input  logic [TAG_W-1:0] set_tag,
   input  logic             inv_en,
   input  logic [IDX_W-1:0] inv_index,
   input  logic             inv2_en,
   input  logic [IDX_W-1:0] inv2_index
);

   logic [LINES-1:0] valid_r;
   logic [TAG_W-1:0] tag_r  [LINES];
   logic [31:0]      data_r [LINES][WPL];

   // Combinational lookups.
   always_comb begin
      lk_hit  = valid_r[lk_index] && (tag_r[lk_index] == lk_tag);
      lk_data = data_r[lk_index][lk_word];
      lk2_hit = valid_r[lk2_index] && (tag_r[lk2_index] == lk2_tag);
   end

   // Valid bits: reset clears everything, so an interrupted refill never survives.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= '0;
      end else begin
         if (inv_en)    valid_r[inv_index]  <= 1'b0;
         if (inv2_en)   valid_r[inv2_index] <= 1'b0;
         if (set_valid) valid_r[set_index]  <= 1'b1;
      end
   end

   // Tag storage, qualified by the valid bits.
   always_ff @(posedge clk) begin
      if (set_valid) tag_r[set_index] <= set_tag;
   end

   // Data storage, qualified by the valid bits.
   always_ff @(posedge clk) begin
      if (wr_en) data_r[wr_index][wr_word] <= wr_data;
   end

endmodule

// File: rtl/dcache_wt_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_wt_ctrl
// Direct-mapped, write-through, no-write-allocate data cache controller.
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   CPU request handshake (ready only in IDLE, not in rst)
//   req_w_en          0000 read, 0001/0011/1111 byte/half/word write
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   resp_valid        one-cycle pulse per accepted request
//   resp_rdata        load data (0 for writes)
//   mem_w_en/mem_address/mem_write_data  SRAM initiator outputs
//   mem_read_data     SRAM combinational read data
// Address layout: {tag, index, word, offset[1:0]}.
// -----------------------------------------------------------------------------
module dcache_wt_ctrl
   import dcache_pkg::*;
#(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter int ADDR_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_w_en,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic [3:0]        mem_w_en,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data
);

   localparam int IDX_W      = $clog2(LINES);
   localparam int WRD_W      = $clog2(WORDS_PER_LINE);
   localparam int LINE_LSB   = WRD_W + 2;
   localparam int UPPER_W    = ADDR_W - LINE_LSB;
   localparam int TAG_W      = UPPER_W - IDX_W;
   localparam int LINE_BYTES = WORDS_PER_LINE * 4;

   state_e              state_r, state_n;
   logic [WRD_W-1:0]    cnt_r, cnt_n, cnt_inc_s;
   logic [31:0]         word_buf_r, word_buf_n;
   logic [ADDR_W-1:0]   addr_r;
   logic [3:0]          w_en_r;
   logic [31:0]         wdata_r;
   logic                resp_valid_r, resp_valid_n;
   logic [31:0]         resp_rdata_r, resp_rdata_n;
   logic [3:0]          mem_w_en_r, mem_w_en_n;
   logic [ADDR_W-1:0]   mem_address_r, mem_address_n;
   logic [31:0]         mem_write_data_r, mem_write_data_n;
   logic                accept_s;

   // Fields of the latched address.
   logic [TAG_W-1:0]    a_tag_s;
   logic [IDX_W-1:0]    a_idx_s;
   logic [WRD_W-1:0]    a_word_s;
   logic [1:0]          a_off_s;

   // Lookup port: request address while idle, latched address otherwise.
   logic [ADDR_W-3:0]   lk_line_s;
   logic                lk_hit_s, lk2_hit_s;
   logic [31:0]         lk_data_s;

   // Line of addr+3: only the line part changes, by a carry out of the line.
   logic                p3_carry_s;
   logic [UPPER_W-1:0]  p3_upper_s;

   // Array control.
   logic                wr_en_s, set_valid_s, inv_en_s, inv2_en_s;
   logic [WRD_W-1:0]    wr_word_s;
   logic [31:0]         wr_data_s;

   assign req_ready      = (state_r == ST_IDLE) && !rst;
   assign accept_s       = req_valid && req_ready;
   assign resp_valid     = resp_valid_r;
   assign resp_rdata     = resp_rdata_r;
   assign mem_w_en       = mem_w_en_r;
   assign mem_address    = mem_address_r;
   assign mem_write_data = mem_write_data_r;

   // Address decomposition and addr+3 line computation.
   always_comb begin
      a_tag_s    = addr_r[ADDR_W-1 -: TAG_W];
      a_idx_s    = addr_r[LINE_LSB +: IDX_W];
      a_word_s   = addr_r[2 +: WRD_W];
      a_off_s    = addr_r[1:0];
      lk_line_s  = (state_r == ST_IDLE) ? req_addr[ADDR_W-1:2] : addr_r[ADDR_W-1:2];
      p3_carry_s = (addr_r[LINE_LSB-1:0] > LINE_LSB'(LINE_BYTES - 4));
      p3_upper_s = addr_r[ADDR_W-1:LINE_LSB] + UPPER_W'(p3_carry_s);
      cnt_inc_s  = cnt_r + WRD_W'(1);
   end

   dcache_array #(
      .LINES (LINES),
      .WPL   (WORDS_PER_LINE),
      .TAG_W (TAG_W)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .lk_index   (lk_line_s[WRD_W +: IDX_W]),
      .lk_word    (lk_line_s[WRD_W-1:0]),
      .lk_tag     (lk_line_s[ADDR_W-3 -: TAG_W]),
      .lk_hit     (lk_hit_s),
      .lk_data    (lk_data_s),
      .lk2_index  (p3_upper_s[IDX_W-1:0]),
      .lk2_tag    (p3_upper_s[UPPER_W-1 -: TAG_W]),
      .lk2_hit    (lk2_hit_s),
      .wr_en      (wr_en_s),
      .wr_index   (a_idx_s),
      .wr_word    (wr_word_s),
      .wr_data    (wr_data_s),
      .set_valid  (set_valid_s),
      .set_index  (a_idx_s),
      .set_tag    (a_tag_s),
      .inv_en     (inv_en_s),
      .inv_index  (a_idx_s),
      .inv2_en    (inv2_en_s),
      .inv2_index (p3_upper_s[IDX_W-1:0])
   );

   // Next-state, next-output and cache-update decisions.
   always_comb begin
      state_n          = state_r;
      cnt_n            = cnt_r;
      word_buf_n       = word_buf_r;
      resp_valid_n     = 1'b0;
      resp_rdata_n     = 32'h0000_0000;
      mem_w_en_n       = W_EN_READ;
      mem_address_n    = '0;
      mem_write_data_n = 32'h0000_0000;
      wr_en_s          = 1'b0;
      wr_word_s        = a_word_s;
      wr_data_s        = 32'h0000_0000;
      set_valid_s      = 1'b0;
      inv_en_s         = 1'b0;
      inv2_en_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (req_w_en != W_EN_READ) begin
                  state_n          = ST_WRITE;
                  mem_w_en_n       = req_w_en;
                  mem_address_n    = req_addr;
                  mem_write_data_n = req_wdata;
               end else if (!is_aligned(req_w_en, req_addr[1:0])) begin
                  state_n       = ST_BYPASS;
                  mem_address_n = req_addr;
               end else if (lk_hit_s) begin
                  resp_valid_n = 1'b1;
                  resp_rdata_n = lk_data_s;
               end else begin
                  state_n       = ST_REFILL;
                  cnt_n         = '0;
                  mem_address_n = {req_addr[ADDR_W-1:LINE_LSB], {WRD_W{1'b0}}, 2'b00};
               end
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_REFILL: begin
            wr_en_s   = 1'b1;
            wr_word_s = cnt_r;
            wr_data_s = mem_read_data;
            if (cnt_r == a_word_s) begin
               word_buf_n = mem_read_data;
            end else begin
               word_buf_n = word_buf_r;
            end
            if (cnt_r == WRD_W'(WORDS_PER_LINE - 1)) begin
               set_valid_s  = 1'b1;
               state_n      = ST_IDLE;
               resp_valid_n = 1'b1;
               resp_rdata_n = (cnt_r == a_word_s) ? mem_read_data : word_buf_r;
            end else begin
               cnt_n         = cnt_inc_s;
               mem_address_n = {addr_r[ADDR_W-1:LINE_LSB], cnt_inc_s, 2'b00};
            end
         end
         ST_BYPASS: begin
            state_n      = ST_IDLE;
            resp_valid_n = 1'b1;
            resp_rdata_n = mem_read_data;
         end
         ST_WRITE: begin
            state_n      = ST_IDLE;
            resp_valid_n = 1'b1;
            if (!is_legal_w_en(w_en_r)) begin
               wr_en_s = 1'b0;
            end else if (is_aligned(w_en_r, a_off_s)) begin
               // Merge lands at the same edge as the SRAM write.
               wr_en_s   = lk_hit_s;
               wr_data_s = merge_bytes(lk_data_s, wdata_r, w_en_r, a_off_s);
            end else begin
               // Straddling store: drop any cached copy of either end.
               inv_en_s  = lk_hit_s;
               inv2_en_s = lk2_hit_s;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State, output and request-latch registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= ST_IDLE;
         cnt_r            <= '0;
         word_buf_r       <= 32'h0000_0000;
         addr_r           <= '0;
         w_en_r           <= W_EN_READ;
         wdata_r          <= 32'h0000_0000;
         resp_valid_r     <= 1'b0;
         resp_rdata_r     <= 32'h0000_0000;
         mem_w_en_r       <= W_EN_READ;
         mem_address_r    <= '0;
         mem_write_data_r <= 32'h0000_0000;
      end else begin
         state_r          <= state_n;
         cnt_r            <= cnt_n;
         word_buf_r       <= word_buf_n;
         resp_valid_r     <= resp_valid_n;
         resp_rdata_r     <= resp_rdata_n;
         mem_w_en_r       <= mem_w_en_n;
         mem_address_r    <= mem_address_n;
         mem_write_data_r <= mem_write_data_n;
         if (accept_s) begin
            addr_r  <= req_addr;
            w_en_r  <= req_w_en;
            wdata_r <= req_wdata;
         end
      end
   end

endmodule

// File: tb/tb_dcache_wt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_wt_ctrl
// Directed bench: a behavioural byte SRAM, a table of CPU requests with
// hand-computed responses, latencies and SRAM beat addresses, and a few
// hand-written sequences (reset, back-to-back hits, reset mid-refill).
// -----------------------------------------------------------------------------
module tb_dcache_wt_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_w_en;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [3:0]  mem_w_en;
   logic [15:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   int n_checks = 0;
   int n_err    = 0;

   dcache_wt_ctrl #(.LINES(16), .WORDS_PER_LINE(4), .ADDR_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_w_en       (req_w_en),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .mem_w_en       (mem_w_en),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: combinational little-endian read, write at posedge.
   logic [7:0] sram [65536];
   bit         loaded = 1'b0;

   assign mem_read_data = {sram[mem_address + 16'd3], sram[mem_address + 16'd2],
                           sram[mem_address + 16'd1], sram[mem_address]};

   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 65536; i++) sram[i] <= 8'h00;
         for (int k = 0; k < 4; k++) sram[k] <= 8'(k);              // 0x0000: 03020100
         for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) begin
               sram[16'(32'h0100 + 4*w + k)] <= 8'(8'h11 * (w + 1)); // 11..44
               sram[16'(32'h0110 + 4*w + k)] <= 8'(8'h11 * (w + 5)); // 55..88
            end
         end
         sram[16'h0300] <= 8'h00; sram[16'h0301] <= 8'h03;            // CAFE0300
         sram[16'h0302] <= 8'hFE; sram[16'h0303] <= 8'hCA;
         loaded <= 1'b1;
      end else begin
         case (mem_w_en)
            4'b1111: for (int k = 0; k < 4; k++) sram[16'(mem_address + 16'(k))] <= mem_write_data[8*k +: 8];
            4'b0011: for (int k = 0; k < 2; k++) sram[16'(mem_address + 16'(k))] <= mem_write_data[8*k +: 8];
            4'b0001: sram[mem_address] <= mem_write_data[7:0];
            default: ;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Results of the last do_req.
   logic [31:0] got_rdata;
   int          got_lat;
   int          got_beats;
   logic [15:0] beat_addr [8];
   logic [3:0]  seen_w_en;
   logic [15:0] seen_w_addr;
   logic [31:0] seen_w_data;

   task automatic do_req(input logic [3:0] w, input logic [15:0] a, input logic [31:0] d);
      int  wait_cyc;
      bit  got;
      @(negedge clk);
      req_valid = 1'b1; req_w_en = w; req_addr = a; req_wdata = d;
      wait_cyc = 0;
      while (!req_ready && wait_cyc < 20) begin
         @(negedge clk);
         wait_cyc++;
      end
      chk("req_ready before accept", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_w_en = 4'b0000; req_addr = 16'h0000; req_wdata = 32'h0;
      got = 1'b0; got_lat = 0; got_beats = 0; got_rdata = 32'h0;
      seen_w_en = 4'b0000; seen_w_addr = 16'h0000; seen_w_data = 32'h0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (resp_valid) begin
            got = 1'b1; got_lat = cyc; got_rdata = resp_rdata;
            break;
         end else if (mem_w_en != 4'b0000) begin
            seen_w_en = mem_w_en; seen_w_addr = mem_address; seen_w_data = mem_write_data;
         end else begin
            if (got_beats < 8) beat_addr[got_beats] = mem_address;
            got_beats++;
         end
      end
      chk("resp timeout", {31'd0, got}, 32'd1);
      @(negedge clk);
      chk("resp_valid is a single pulse", {31'd0, resp_valid}, 32'd0);
   endtask

   typedef struct {
      logic [3:0]  w_en;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_beats;
      logic [15:0] exp_beat0;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   initial begin
      // w_en, addr, wdata, rdata, latency, read beats, first beat address
      vecs[0]  = '{4'b0000, 16'h0104, 32'h0,        32'h22222222, 5, 4, 16'h0100}; // refill
      vecs[1]  = '{4'b0000, 16'h0108, 32'h0,        32'h33333333, 1, 0, 16'h0000}; // hit
      vecs[2]  = '{4'b0001, 16'h0109, 32'h000000AB, 32'h0,        2, 0, 16'h0000}; // byte write hit
      vecs[3]  = '{4'b0000, 16'h0108, 32'h0,        32'h3333AB33, 1, 0, 16'h0000};
      vecs[4]  = '{4'b1111, 16'h0200, 32'hDEADBEEF, 32'h0,        2, 0, 16'h0000}; // write miss
      vecs[5]  = '{4'b0000, 16'h0200, 32'h0,        32'hDEADBEEF, 5, 4, 16'h0200}; // no allocate
      vecs[6]  = '{4'b0000, 16'h0102, 32'h0,        32'h22221111, 2, 1, 16'h0102}; // bypass
      vecs[7]  = '{4'b0000, 16'h0110, 32'h0,        32'h55555555, 5, 4, 16'h0110};
      vecs[8]  = '{4'b0000, 16'h0100, 32'h0,        32'h11111111, 5, 4, 16'h0100};
      vecs[9]  = '{4'b0011, 16'h010F, 32'h0000BEEF, 32'h0,        2, 0, 16'h0000}; // crossing half
      vecs[10] = '{4'b0000, 16'h010C, 32'h0,        32'hEF444444, 5, 4, 16'h0100};
      vecs[11] = '{4'b0000, 16'h0110, 32'h0,        32'h555555BE, 5, 4, 16'h0110};
      vecs[12] = '{4'b0101, 16'h0104, 32'h12345678, 32'h0,        2, 0, 16'h0000}; // undefined w_en
      vecs[13] = '{4'b0000, 16'h0104, 32'h0,        32'h22222222, 1, 0, 16'h0000};
      vecs[14] = '{4'b0011, 16'h0106, 32'h00007777, 32'h0,        2, 0, 16'h0000}; // half hit, off 2
      vecs[15] = '{4'b0000, 16'h0104, 32'h0,        32'h77772222, 1, 0, 16'h0000};
      vecs[16] = '{4'b0000, 16'h0000, 32'h0,        32'h03020100, 5, 4, 16'h0000};
      vecs[17] = '{4'b1111, 16'hFFFE, 32'hA1B2C3D4, 32'h0,        2, 0, 16'h0000}; // wraps to 0x0001
      vecs[18] = '{4'b0000, 16'h0000, 32'h0,        32'h0302A1B2, 5, 4, 16'h0000};

      rst = 1'b1; req_valid = 1'b0; req_w_en = 4'b0000; req_addr = 16'h0000; req_wdata = 32'h0;

      // Reset state.
      repeat (3) @(negedge clk);
      req_valid = 1'b1;
      chk("rst req_ready",     {31'd0, req_ready},  32'd0);
      chk("rst resp_valid",    {31'd0, resp_valid}, 32'd0);
      chk("rst resp_rdata",    resp_rdata,          32'h0);
      chk("rst mem_w_en",      {28'd0, mem_w_en},   32'd0);
      chk("rst mem_address",   {16'd0, mem_address}, 32'd0);
      chk("rst mem_write_data", mem_write_data,     32'h0);
      req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("idle req_ready", {31'd0, req_ready}, 32'd1);

      // Table-driven transactions.
      for (int i = 0; i < NV; i++) begin
         do_req(vecs[i].w_en, vecs[i].addr, vecs[i].wdata);
         chk($sformatf("v%0d rdata", i),   got_rdata,         vecs[i].exp_rdata);
         chk($sformatf("v%0d latency", i), 32'(got_lat),      32'(vecs[i].exp_lat));
         chk($sformatf("v%0d beats", i),   32'(got_beats),    32'(vecs[i].exp_beats));
         for (int k = 0; k < vecs[i].exp_beats && k < got_beats && k < 8; k++)
            chk($sformatf("v%0d beat%0d addr", i, k), {16'd0, beat_addr[k]},
                {16'd0, 16'(vecs[i].exp_beat0 + 16'(4*k))});
         if (vecs[i].w_en != 4'b0000) begin
            chk($sformatf("v%0d mem_w_en", i),       {28'd0, seen_w_en},   {28'd0, vecs[i].w_en});
            chk($sformatf("v%0d mem_address", i),    {16'd0, seen_w_addr}, {16'd0, vecs[i].addr});
            chk($sformatf("v%0d mem_write_data", i), seen_w_data,          vecs[i].wdata);
         end
      end

      // Back-to-back hits on line 0x0110 (words 555555BE, 66666666).
      @(negedge clk);
      req_valid = 1'b1; req_w_en = 4'b0000; req_addr = 16'h0110;
      @(negedge clk);
      chk("b2b first resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("b2b first rdata",      resp_rdata,           32'h555555BE);
      chk("b2b ready",            {31'd0, req_ready},   32'd1);
      req_addr = 16'h0114;
      @(negedge clk);
      chk("b2b second resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("b2b second rdata",      resp_rdata,           32'h66666666);
      req_valid = 1'b0; req_addr = 16'h0000;
      @(negedge clk);
      chk("b2b idle resp_valid", {31'd0, resp_valid}, 32'd0);

      // Reset during the second refill beat of 0x0300.
      req_valid = 1'b1; req_addr = 16'h0300;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_addr = 16'h0000;
      @(negedge clk);
      chk("mid-refill beat0", {16'd0, mem_address}, 32'h0000_0300);
      @(negedge clk);
      chk("mid-refill beat1", {16'd0, mem_address}, 32'h0000_0304);
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("abort c%0d req_ready", c),  {31'd0, req_ready},  32'd0);
         chk($sformatf("abort c%0d resp_valid", c), {31'd0, resp_valid}, 32'd0);
         chk($sformatf("abort c%0d mem_address", c), {16'd0, mem_address}, 32'd0);
      end
      rst = 1'b0;
      do_req(4'b0000, 16'h0300, 32'h0);
      chk("post-abort rdata",   got_rdata,      32'hCAFE0300);
      chk("post-abort latency", 32'(got_lat),   32'd5);
      chk("post-abort beats",   32'(got_beats), 32'd4);
      // Line 0x0110 was valid before reset, so it must refill now.
      do_req(4'b0000, 16'h0114, 32'h0);
      chk("post-reset refill rdata",   got_rdata,    32'h66666666);
      chk("post-reset refill latency", 32'(got_lat), 32'd5);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
